// File: rtl/enc_data_pkg.sv
// Shared types and constants for the encoder data-handling path.
// Provides the macroblock scan state encoding, CIF frame defaults and
// helpers that derive macroblock counts and counter widths from frame size.
package enc_data_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_DONE = 2'd2,
    NEXT      = 2'd3
  } scan_state_t;

  // CIF luma frame defaults
  localparam int CIF_WIDTH   = 352;
  localparam int CIF_HEIGHT  = 288;
  localparam int CIF_MB_SIZE = 16;
  localparam int CIF_ADDR_W  = 24;

  function automatic int mbs_x(input int width, input int mb_size);
    return width / mb_size;
  endfunction

  function automatic int mbs_y(input int height, input int mb_size);
    return height / mb_size;
  endfunction

  // Counter width that stays at least one bit when there is a single macroblock
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mb_addr_gen.sv
// Row-fetch address generator: tracks row within the MB and the frame address of that row.
// Latency: address registered; a new address is presented the cycle after each step input.
// Backpressure: address and row only move on accept/step pulses, so a stalled request holds still.
// Ports: load_i/base_i restart at the frame base; accept_i moves down one row; col_step_i moves to
//        the next MB in the same band; band_step_i moves to column 0 of the next band;
//        addr_o is the current row address; row_last_o flags the final row of the MB.
module mb_addr_gen
  import enc_data_pkg::*;
#(
  parameter int WIDTH   = CIF_WIDTH,
  parameter int MB_SIZE = CIF_MB_SIZE,
  parameter int ADDR_W  = CIF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              accept_i,
  input  logic              col_step_i,
  input  logic              band_step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              row_last_o
);

  localparam int ROW_W = $clog2(MB_SIZE);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(MB_SIZE);
  localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(MB_SIZE * WIDTH);

  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] band_q, band_d;   // address of row 0, column 0 of the current MB band
  logic [ADDR_W-1:0] col_q, col_d;     // address of row 0 of the current MB
  logic [ADDR_W-1:0] addr_q, addr_d;   // address of the current row of the current MB
  logic [ADDR_W-1:0] band_next, col_next;

  // All sums wrap naturally modulo 2^ADDR_W
  assign band_next = band_q + BAND_STEP;
  assign col_next  = col_q + COL_STEP;

  always_comb begin
    row_d  = row_q;
    band_d = band_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (load_i) begin
      row_d  = '0;
      band_d = base_i;
      col_d  = base_i;
      addr_d = base_i;
    end else if (band_step_i) begin
      row_d  = '0;
      band_d = band_next;
      col_d  = band_next;
      addr_d = band_next;
    end else if (col_step_i) begin
      row_d  = '0;
      col_d  = col_next;
      addr_d = col_next;
    end else if (accept_i) begin
      row_d  = row_q + 1'b1;
      addr_d = addr_q + ROW_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      band_q <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      band_q <= band_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o     = addr_q;
  assign row_last_o = (row_q == ROW_W'(MB_SIZE - 1));

endmodule

// File: rtl/mb_scan_controller.sv
// Frame-level macroblock sequencer: raster walk of the frame, MB_SIZE row fetches per MB.
// Latency: per MB 1 (NEXT) + MB_SIZE (FETCH, ready held high) + WAIT_DONE cycles until mb_done.
// Backpressure: req_valid/req_ready handshake; req_addr holds while stalled; waits on mb_done.
// Ports: start/frame_base begin a frame (IDLE only); busy spans the frame; req_valid/req_ready/
//        req_addr carry row fetches; mb_x/mb_y/mb_first/mb_last describe the current MB;
//        mb_start pulses as each MB begins; mb_done ends an MB; frame_done pulses at frame end.
module mb_scan_controller
  import enc_data_pkg::*;
#(
  parameter int WIDTH   = CIF_WIDTH,
  parameter int HEIGHT  = CIF_HEIGHT,
  parameter int MB_SIZE = CIF_MB_SIZE,
  parameter int ADDR_W  = CIF_ADDR_W,
  localparam int MBS_X  = mbs_x(WIDTH, MB_SIZE),
  localparam int MBS_Y  = mbs_y(HEIGHT, MB_SIZE),
  localparam int XW     = cnt_w(MBS_X),
  localparam int YW     = cnt_w(MBS_Y)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              busy,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [XW-1:0]     mb_x,
  output logic [YW-1:0]     mb_y,
  output logic              mb_start,
  output logic              mb_first,
  output logic              mb_last,
  input  logic              mb_done,
  output logic              frame_done
);

  if (WIDTH % MB_SIZE != 0) begin : g_bad_width
    $error("mb_scan_controller: WIDTH must be a multiple of MB_SIZE");
  end
  if (HEIGHT % MB_SIZE != 0) begin : g_bad_height
    $error("mb_scan_controller: HEIGHT must be a multiple of MB_SIZE");
  end
  if (MB_SIZE < 4 || (MB_SIZE & (MB_SIZE - 1)) != 0) begin : g_bad_mb_size
    $error("mb_scan_controller: MB_SIZE must be a power of two, at least 4");
  end
  if (ADDR_W < $clog2(WIDTH * HEIGHT)) begin : g_bad_addr_w
    $error("mb_scan_controller: ADDR_W too small for the frame");
  end

  localparam logic [XW-1:0] X_LAST = XW'(MBS_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(MBS_Y - 1);

  scan_state_t   state_q, state_d;
  logic          busy_q, busy_d;
  logic          mb_start_q, mb_start_d;
  logic          frame_done_q, frame_done_d;
  logic [XW-1:0] mb_x_q, mb_x_d;
  logic [YW-1:0] mb_y_q, mb_y_d;

  logic load, accept, col_step, band_step, row_last;
  logic at_last_mb;

  assign at_last_mb = (mb_x_q == X_LAST) && (mb_y_q == Y_LAST);

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    mb_start_d   = 1'b0;
    frame_done_d = 1'b0;
    mb_x_d       = mb_x_q;
    mb_y_d       = mb_y_q;
    load         = 1'b0;
    accept       = 1'b0;
    col_step     = 1'b0;
    band_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          busy_d     = 1'b1;
          mb_start_d = 1'b1;
          mb_x_d     = '0;
          mb_y_d     = '0;
          load       = 1'b1;
        end
      end
      FETCH: begin
        if (req_ready) begin
          accept = 1'b1;
          if (row_last) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (mb_done) begin
          if (at_last_mb) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        state_d    = FETCH;
        mb_start_d = 1'b1;
        if (mb_x_q == X_LAST) begin
          mb_x_d    = '0;
          mb_y_d    = mb_y_q + 1'b1;
          band_step = 1'b1;
        end else begin
          mb_x_d   = mb_x_q + 1'b1;
          col_step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      mb_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      mb_x_q       <= '0;
      mb_y_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      mb_start_q   <= mb_start_d;
      frame_done_q <= frame_done_d;
      mb_x_q       <= mb_x_d;
      mb_y_q       <= mb_y_d;
    end
  end

  mb_addr_gen #(
    .WIDTH  (WIDTH),
    .MB_SIZE(MB_SIZE),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .base_i     (frame_base),
    .accept_i   (accept),
    .col_step_i (col_step),
    .band_step_i(band_step),
    .addr_o     (req_addr),
    .row_last_o (row_last)
  );

  assign busy       = busy_q;
  assign req_valid  = (state_q == FETCH);
  assign mb_x       = mb_x_q;
  assign mb_y       = mb_y_q;
  assign mb_start   = mb_start_q;
  assign frame_done = frame_done_q;
  // Gated by busy so position flags read 0 out of reset and between frames
  assign mb_first   = busy_q && (mb_x_q == '0) && (mb_y_q == '0);
  assign mb_last    = busy_q && at_last_mb;

endmodule

// File: tb/tb_mb_scan_controller.sv
module tb_mb_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: CIF defaults
  logic        a_start, a_busy, a_req_valid, a_req_ready;
  logic [23:0] a_base, a_req_addr;
  logic [4:0]  a_mb_x, a_mb_y;
  logic        a_mb_start, a_mb_first, a_mb_last, a_mb_done, a_frame_done;

  // Instance B: 32x16 frame, two macroblocks
  logic        b_start, b_busy, b_req_valid, b_req_ready;
  logic [23:0] b_base, b_req_addr;
  logic [0:0]  b_mb_x, b_mb_y;
  logic        b_mb_start, b_mb_first, b_mb_last, b_mb_done, b_frame_done;

  int vecs = 0;
  int miss = 0;

  mb_scan_controller u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .frame_base(a_base), .busy(a_busy),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .mb_x(a_mb_x), .mb_y(a_mb_y), .mb_start(a_mb_start), .mb_first(a_mb_first),
    .mb_last(a_mb_last), .mb_done(a_mb_done), .frame_done(a_frame_done)
  );

  mb_scan_controller #(.WIDTH(32), .HEIGHT(16), .MB_SIZE(16), .ADDR_W(24)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .frame_base(b_base), .busy(b_busy),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .mb_x(b_mb_x), .mb_y(b_mb_y), .mb_start(b_mb_start), .mb_first(b_mb_first),
    .mb_last(b_mb_last), .mb_done(b_mb_done), .frame_done(b_frame_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: address of row r of raster MB number k, straight from the frame geometry
  function automatic logic [23:0] model_addr(input logic [23:0] base, input int w,
                                             input int k, input int r);
    int mbx;
    int x;
    int y;
    longint off;
    mbx = w / 16;
    x   = k % mbx;
    y   = k / mbx;
    off = longint'((y * 16 + r) * w + x * 16);
    return 24'(longint'(base) + off);
  endfunction

  task automatic drive(input bit sel, input bit st, input bit rdy, input bit md,
                       input logic [23:0] base);
    if (sel) begin
      b_start = st; b_req_ready = rdy; b_mb_done = md; b_base = base;
    end else begin
      a_start = st; a_req_ready = rdy; a_mb_done = md; a_base = base;
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk(tag, {a_busy, a_req_valid, a_req_addr, a_mb_x, a_mb_y,
              a_mb_start, a_mb_first, a_mb_last, a_frame_done}, 64'd0);
  endtask

  // Runs one frame on instance sel. rnd adds random backpressure, random mb_done delay,
  // spurious start / mb_done. abort_k >= 0 asserts rst on the 5th request of MB abort_k.
  task automatic run_frame(input bit sel, input int w, input int h, input logic [23:0] base,
                           input bit rnd, input int abort_k);
    int mbx, nmb, cur_k, acc, wcnt, wtarget, cyc, last_st, x, y;
    bit held, done_sent, exp_fd, fin, aborted, rdy, md, st;
    logic [23:0] held_addr, a;
    logic v, bsy, ms, fd, first, last;
    mbx = w / 16; nmb = mbx * (h / 16);
    cur_k = -1; acc = 0; wcnt = 0; wtarget = 2; cyc = 0; last_st = 0;
    held = 0; done_sent = 0; exp_fd = 0; fin = 0; aborted = 0; held_addr = '0;
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, 1'b0, base);
    @(negedge clk);
    while (!fin && !aborted && cyc < 60000) begin
      if (sel) begin
        v = b_req_valid; bsy = b_busy; ms = b_mb_start; fd = b_frame_done; a = b_req_addr;
        first = b_mb_first; last = b_mb_last; x = int'(b_mb_x); y = int'(b_mb_y);
      end else begin
        v = a_req_valid; bsy = a_busy; ms = a_mb_start; fd = a_frame_done; a = a_req_addr;
        first = a_mb_first; last = a_mb_last; x = int'(a_mb_x); y = int'(a_mb_y);
      end
      if (ms) begin
        if (cur_k >= 0) chk("accepts_per_mb", acc, 16);
        cur_k++;
        chk("mb_start_with_valid", v, 1'b1);
        if (!rnd && cur_k > 0) chk("mb_interval", cyc - last_st, 20);
        last_st = cyc; acc = 0; wcnt = 0; done_sent = 0;
        wtarget = rnd ? int'($urandom_range(0, 3)) : 2;
      end
      if (held && v) chk("stall_addr_hold", a, held_addr);
      held = 0;
      chk("frame_done", fd, exp_fd);
      if (exp_fd) begin
        chk("busy_at_frame_end", bsy, 1'b0);
        chk("mb_start_count", cur_k + 1, nmb);
        fin = 1;
      end else begin
        chk("busy", bsy, 1'b1);
        chk("mb_x", x, cur_k % mbx);
        chk("mb_y", y, cur_k / mbx);
        chk("mb_first", first, cur_k == 0);
        chk("mb_last", last, cur_k == nmb - 1);
      end
      if (!fin) begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        md = 0; st = 0;
        if (v) begin
          if (cur_k == abort_k && acc == 4) aborted = 1;
          else if (rdy) begin
            chk("req_addr", a, model_addr(base, w, cur_k, acc));
            acc++;
          end else begin
            held = 1; held_addr = a;
          end
          if (rnd && $urandom_range(0, 7) == 0) md = 1;
        end else if (!done_sent) begin
          if (wcnt == wtarget) begin
            md = 1; done_sent = 1; exp_fd = (cur_k == nmb - 1);
          end
          wcnt++;
        end
        if (rnd && $urandom_range(0, 15) == 0) st = 1;
        if (aborted) begin
          rst = 1'b1;
          drive(sel, 1'b0, 1'b0, 1'b0, base);
        end else begin
          drive(sel, st, rdy, md, st ? 24'($urandom) : base);
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin && !aborted) chk("frame_timeout", 1'b0, 1'b1);
    drive(sel, 1'b0, 1'b0, 1'b0, base);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    repeat (3) @(negedge clk);
    chk_zero_a("reset_state_a");
    chk("reset_state_b", {b_busy, b_req_valid, b_req_addr, b_mb_x, b_mb_y,
                          b_mb_start, b_mb_first, b_mb_last, b_frame_done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full CIF frame, no backpressure, mb_done two cycles into WAIT_DONE
    run_frame(1'b0, 352, 288, 24'h000000, 1'b0, -100);
    // Base near the top of the address space: addresses wrap; random stalls and noise
    run_frame(1'b0, 352, 288, 24'hFFFFF0, 1'b1, -100);
    // Reset on the 5th request of MB(3,2)
    run_frame(1'b0, 352, 288, 24'($urandom), 1'b1, 2 * 22 + 3);
    chk_zero_a("abort_reset_outputs");
    rst = 1'b0;
    // Fresh frame after the abort restarts at MB(0,0) with the new base
    run_frame(1'b0, 352, 288, 24'($urandom), 1'b0, -100);
    // Two-macroblock frame
    run_frame(1'b1, 32, 16, 24'h000100, 1'b0, -100);
    run_frame(1'b1, 32, 16, 24'($urandom), 1'b1, -100);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/mb_scan_controller.md
Name: mb_scan_controller

Overview:
- Frame-level macroblock sequencer for the encoder data-handling path.
- On `start`, walks a WIDTH x HEIGHT luma frame in raster macroblock order.
- For each macroblock, issues MB_SIZE row-fetch requests to the frame-memory reader over a valid/ready handshake, then waits for the downstream encode pipeline to report `mb_done`.
- Generalised over frame size, macroblock size and address width; adds backpressure, a frame base address and per-MB status flags.

Parameters:
- WIDTH, 352, frame width in pixels; must be a multiple of MB_SIZE.
- HEIGHT, 288, frame height in pixels; must be a multiple of MB_SIZE.
- MB_SIZE, 16, macroblock edge in pixels; power of two, at least 4.
- ADDR_W, 24, width of pixel (byte) addresses; must be at least clog2(WIDTH*HEIGHT).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin frame; sampled only in IDLE
- frame_base  in  ADDR_W  frame start address; latched on accepted start
- busy  out  1  high from the cycle after accepted start until frame end
- req_valid  out  1  row-fetch request valid
- req_ready  in  1  reader accepts request
- req_addr  out  ADDR_W  address of first pixel of the row (MB_SIZE contiguous bytes)
- mb_x  out  clog2(WIDTH/MB_SIZE)  current macroblock column
- mb_y  out  clog2(HEIGHT/MB_SIZE)  current macroblock row
- mb_start  out  1  one-cycle pulse as each macroblock's fetch begins
- mb_first  out  1  current MB is (0,0)
- mb_last  out  1  current MB is the last one in the frame
- mb_done  in  1  encode pipeline finished the current MB
- frame_done  out  1  one-cycle pulse after the last MB's mb_done

Behaviour:
- Reset values: all outputs 0; state IDLE; row counter 0; base register 0.
- Reset is honoured from any state, mid-frame included. Any outstanding request is dropped, with no completion pulse.

States:
- IDLE
  - start=1 -> FETCH; latch frame_base; mb_x=mb_y=row=0; busy=1; mb_start pulses in the first FETCH cycle.
  - start=0 -> stay.
- FETCH
  - req_valid=1.
  - req_addr = base + (mb_y*MB_SIZE + row)*WIDTH + mb_x*MB_SIZE, computed modulo 2^ADDR_W.
  - req_addr is registered and must be stable while req_valid=1 and req_ready=0.
  - On req_valid & req_ready: row++, and the next address is presented the following cycle. Sustained throughput is one request per cycle when req_ready is held high.
  - Acceptance with row == MB_SIZE-1 -> WAIT_DONE, with req_valid low the next cycle.
- WAIT_DONE
  - req_valid=0.
  - mb_done=1 and not last MB -> NEXT.
  - mb_done=1 and last MB -> IDLE; frame_done pulses 1 cycle; busy=0 in the same cycle.
- NEXT (one cycle)
  - Advance mb_x. At WIDTH/MB_SIZE-1, wrap mb_x to 0 and increment mb_y.
  - row=0; -> FETCH; mb_start pulses.

Other rules:
- start while busy is ignored.
- mb_done outside WAIT_DONE is ignored; it is not queued.
- mb_x, mb_y, mb_first and mb_last are stable from mb_start until the NEXT transition.
- mb_last = (mb_x == WIDTH/MB_SIZE-1) && (mb_y == HEIGHT/MB_SIZE-1).
- Per-MB latency with req_ready=1 and immediate mb_done: 1 (NEXT) + MB_SIZE (FETCH) + 1 (WAIT_DONE) cycles.
- Parameter violations (WIDTH or HEIGHT not a multiple of MB_SIZE; ADDR_W too small) fail at elaboration via an assertion.

Decomposition:
- Shared package `enc_data_pkg`:
  - state enum `scan_state_t` {IDLE, FETCH, WAIT_DONE, NEXT};
  - helper functions for MBS_X = WIDTH/MB_SIZE and MBS_Y = HEIGHT/MB_SIZE;
  - CIF default constants.
- One natural sub-module: `mb_addr_gen`.
  - Holds the row and line-base accumulators.
  - Avoids a per-cycle multiplier: adds WIDTH per row and MB_SIZE per column, and loads the MB_SIZE*WIDTH row-band step on mb_y increment.

Test Plan:
- Defaults, req_ready=1, mb_done 2 cycles after WAIT_DONE entry:
  - MB(0,0) addrs 0, 352, 704 ... 5280;
  - MB(1,0) first addr 16;
  - MB(0,1) first addr 5632;
  - last MB (21,17) row 15 addr 101360;
  - exactly 396 mb_start pulses, then one frame_done.
- Backpressure: req_ready toggles 1,0,0,1 -> req_addr held unchanged across stalls; no row skipped or duplicated; 16 accepts per MB.
- frame_base=0xFFFFF0 with ADDR_W=24 -> MB(0,0) row 1 addr wraps to 0x000150.
- start pulsed mid-frame and mb_done pulsed during FETCH -> both ignored; scan order and counts unchanged.
- rst asserted on the 5th request of MB(3,2) -> next cycle all outputs 0, state IDLE; a fresh start restarts at MB(0,0) addr = new base.
- WIDTH=32, HEIGHT=16, MB_SIZE=16:
  - 2 MBs; mb_first=1 only on MB(0,0), mb_last=1 only on MB(1,0);
  - frame_done is the cycle after the second mb_done.
